// File: rtl/keccak_mask_ctrl.sv
// keccak_mask_ctrl
// Initiator-side controller for the masked Keccak-f[200] core. It takes an
// unmasked state, splits it into D+1 Boolean shares, runs the core through
// its reset/load sequence, waits for the core's Ready rising edge, and
// returns the recombined (unmasked) result.
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   in_valid     in_data valid
//   in_ready     controller can accept a new state
//   in_data      unmasked input state (W bits)
//   mask_rand    fresh randomness for share generation (D*W bits)
//   core_reset   drives the core's active-high reset
//   core_in      shares to the core, share i at [i*W +: W]
//   core_ready   Ready from the core
//   core_out     output shares from the core, share i at [i*W +: W]
//   out_valid    out_data valid
//   out_ready    consumer accepts out_data
//   out_data     unmasked result (W bits)
//   error        sticky timeout flag, cleared only by rst_n

module keccak_mask_ctrl #(
    parameter int D       = 1,
    parameter int W       = 200,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [D*W-1:0]     mask_rand,
    output logic               core_reset,
    output logic [(D+1)*W-1:0] core_in,
    input  logic               core_ready,
    input  logic [(D+1)*W-1:0] core_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               error
);

    localparam int CNT_MAX = (RST_CYC > TIMEOUT) ? RST_CYC : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        OUT
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 ready_q;
    logic                 in_ready_n;
    logic                 core_reset_n;
    logic [(D+1)*W-1:0]   core_in_n;
    logic                 out_valid_n;
    logic [W-1:0]         out_data_n;
    logic                 error_n;

    logic [W-1:0]         last_share;
    logic [W-1:0]         out_xor;
    logic                 ready_rise;

    // The last share carries the data: in_data XOR every mask word, so the
    // XOR of all D+1 shares equals in_data. The unmasked value itself is
    // never registered.
    always_comb begin
        last_share = in_data;
        for (int i = 0; i < D; i++) begin
            last_share = last_share ^ mask_rand[i*W +: W];
        end
    end

    always_comb begin
        out_xor = '0;
        for (int i = 0; i <= D; i++) begin
            out_xor = out_xor ^ core_out[i*W +: W];
        end
    end

    // A Ready that is already high when RUN is entered must not count, so
    // only a 0->1 transition against the registered copy is accepted.
    assign ready_rise = core_ready & ~ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ready_q    <= 1'b0;
            in_ready   <= 1'b0;
            core_reset <= 1'b1;
            core_in    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ready_q    <= core_ready;
            in_ready   <= in_ready_n;
            core_reset <= core_reset_n;
            core_in    <= core_in_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            error      <= error_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        in_ready_n   = in_ready;
        core_reset_n = core_reset;
        core_in_n    = core_in;
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        error_n      = error;

        case (state)
            IDLE: begin
                core_reset_n = 1'b1;
                in_ready_n   = 1'b1;
                if (in_valid && in_ready) begin
                    core_in_n  = {last_share, mask_rand};
                    in_ready_n = 1'b0;
                    cnt_n      = '0;
                    state_n    = LOAD;
                end
            end

            // Core reset already high on entry; hold it RST_CYC cycles in total.
            LOAD: begin
                if (cnt == CW'(RST_CYC - 1)) begin
                    core_reset_n = 1'b0;
                    cnt_n        = '0;
                    state_n      = RUN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            RUN: begin
                if (ready_rise) begin
                    out_data_n  = out_xor;
                    out_valid_n = 1'b1;
                    state_n     = OUT;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    error_n      = 1'b1;
                    core_reset_n = 1'b1;
                    core_in_n    = '0;
                    in_ready_n   = 1'b1;
                    cnt_n        = '0;
                    state_n      = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            OUT: begin
                if (out_valid && out_ready) begin
                    out_valid_n  = 1'b0;
                    core_reset_n = 1'b1;
                    core_in_n    = '0;
                    in_ready_n   = 1'b1;
                    state_n      = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keccak_mask_ctrl.sv
// tb_keccak_mask_ctrl
// Bench for keccak_mask_ctrl. A stub core stands in for keccak_top: it
// recombines the incoming shares, applies a fixed stand-in permutation and
// re-shares the result with fresh randomness, raising Ready a programmable
// number of cycles after its reset falls (or holding Ready high throughout).
// The expected result is computed straight from the unmasked input.

module tb_keccak_mask_ctrl;

    localparam int D       = 1;
    localparam int W       = 200;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 64;
    localparam logic [W-1:0] KCONST = 200'h5a_c3e1_0f96_7b28_d4a1_33cc_e70f_1d2b_8c46_9e05_a7f3_12bd;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic [D*W-1:0]     mask_rand;
    logic               core_reset;
    logic [(D+1)*W-1:0] core_in;
    logic               core_ready;
    logic [(D+1)*W-1:0] core_out;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic               error;

    int n_compared   = 0;
    int n_mismatched = 0;

    keccak_mask_ctrl #(
        .D(D), .W(W), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mask_rand(mask_rand),
        .core_reset(core_reset), .core_in(core_in),
        .core_ready(core_ready), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the core's permutation, defined on unmasked values.
    function automatic logic [W-1:0] modelPermute(input logic [W-1:0] x);
        return {x[W-14:0], x[W-1:W-13]} ^ KCONST;
    endfunction

    function automatic logic [W-1:0] randWord();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < (W + 31) / 32; k++) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    function automatic logic [D*W-1:0] randMask();
        logic [D*W-1:0] m;
        for (int i = 0; i < D; i++) m[i*W +: W] = randWord();
        return m;
    endfunction

    function automatic logic [W-1:0] xorShares(input logic [(D+1)*W-1:0] s);
        logic [W-1:0] x;
        x = '0;
        for (int i = 0; i <= D; i++) x = x ^ s[i*W +: W];
        return x;
    endfunction

    function automatic logic [(D+1)*W-1:0] reshare(input logic [W-1:0] v);
        logic [(D+1)*W-1:0] s;
        logic [W-1:0]       acc;
        acc = v;
        for (int i = 0; i < D; i++) begin
            s[i*W +: W] = randWord();
            acc = acc ^ s[i*W +: W];
        end
        s[D*W +: W] = acc;
        return s;
    endfunction

    // Stub core
    logic tie_high = 1'b0;
    int   stub_lat = 1;
    int   stub_cnt = 0;

    always @(posedge clk) begin
        if (tie_high) begin
            core_ready <= 1'b1;
        end else if (core_reset) begin
            core_ready <= 1'b0;
            stub_cnt   <= 0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == stub_lat - 1) begin
                core_ready <= 1'b1;
                core_out   <= reshare(modelPermute(xorShares(core_in)));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One full transaction through the stub core; hold = cycles out_ready is
    // kept low once out_valid rises (0 means out_ready is already high).
    task automatic applyStimulus(input logic [W-1:0] data, input logic [D*W-1:0] mask,
                                 input int lat, input int hold, input logic [W-1:0] expected,
                                 output logic [W-1:0] share0, output logic [W-1:0] result);
        int           n;
        logic [W-1:0] held;
        logic         stable;
        stub_lat = lat;
        checkOutput("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = data;
        mask_rand = mask;
        out_ready = (hold == 0);
        tick();
        in_valid  = 1'b0;
        in_data   = randWord();
        mask_rand = randMask();
        checkOutput("accept_in_ready", in_ready, 0);
        checkOutput("share_xor", xorShares(core_in), data);
        checkOutput("share0_is_mask", core_in[W-1:0], mask[W-1:0]);
        share0 = core_in[W-1:0];
        n = 0;
        while (core_reset === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checkOutput("core_reset_cycles", n, RST_CYC);
        n = 0;
        while (out_valid !== 1'b1 && n < lat + 20) begin
            tick();
            n++;
        end
        checkOutput("out_latency", n, lat + 1);
        checkOutput("out_data", out_data, expected);
        result = out_data;
        if (hold > 0) begin
            held     = out_data;
            stable   = 1'b1;
            in_valid = 1'b1;
            in_data  = randWord();
            for (int k = 0; k < hold; k++) begin
                tick();
                if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) stable = 1'b0;
            end
            checkOutput("out_hold_stable", stable, 1);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        checkOutput("handshake_out_valid", out_valid, 0);
        checkOutput("handshake_in_ready", in_ready, 1);
        checkOutput("handshake_core_reset", core_reset, 1);
        checkOutput("core_in_cleared", core_in, 0);
        checkOutput("out_data_kept", out_data, expected);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0]   data;
        logic [D*W-1:0] mask;
        int             lat;
        int             hold;
        logic [W-1:0]   expected;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] s0a, s0b, ra, rb, dsame;
        int           n;
        logic         ov_seen;
        int           lats[8]  = '{1, 2, 5, 1, 3, 8, 12, 1};
        int           holds[8] = '{0, 10, 0, 3, 1, 0, 5, 10};

        for (int i = 0; i < 8; i++) begin
            vecs[i].data = randWord();
            vecs[i].mask = randMask();
            vecs[i].lat  = lats[i];
            vecs[i].hold = holds[i];
        end
        vecs[0].data = 200'hffffffffffffffffffffffffffffffff_0123456789abcdef01;
        vecs[1].data = '0;
        vecs[2].data = '1;
        vecs[3].mask = '0;
        for (int i = 0; i < 8; i++) vecs[i].expected = modelPermute(vecs[i].data);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mask_rand = '0;
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_core_reset", core_reset, 1);
        checkOutput("rst_core_in", core_in, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_error", error, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready_low", in_ready, 0);
        tick();
        checkOutput("release_in_ready_high", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].data, vecs[i].mask, vecs[i].lat, vecs[i].hold,
                          vecs[i].expected, s0a, ra);
        end

        for (int i = 0; i < 6; i++) begin
            dsame = randWord();
            applyStimulus(dsame, randMask(), 1 + int'($urandom_range(11)),
                          int'($urandom_range(4)), modelPermute(dsame), s0a, ra);
        end

        dsame = randWord();
        applyStimulus(dsame, randMask(), 3, 0, modelPermute(dsame), s0a, ra);
        applyStimulus(dsame, randMask(), 4, 2, modelPermute(dsame), s0b, rb);
        checkOutput("remask_share0_differs", (s0a != s0b), 1);
        checkOutput("remask_same_result", rb, ra);

        // Reset in the middle of RUN
        stub_lat  = 30;
        in_valid  = 1'b1;
        in_data   = randWord();
        mask_rand = randMask();
        tick();
        in_valid = 1'b0;
        n = 0;
        while (core_reset === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_core_reset", core_reset, 1);
        checkOutput("midrun_in_ready", in_ready, 0);
        checkOutput("midrun_out_valid", out_valid, 0);
        tick();
        checkOutput("midrun_edge_core_reset", core_reset, 1);
        checkOutput("midrun_edge_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("midrun_release_in_ready_low", in_ready, 0);
        tick();
        checkOutput("midrun_release_in_ready", in_ready, 1);
        checkOutput("midrun_release_core_in", core_in, 0);

        // Core Ready stuck high: no rising edge, run must time out
        tie_high = 1'b1;
        doReset();
        in_valid  = 1'b1;
        in_data   = randWord();
        mask_rand = randMask();
        tick();
        in_valid = 1'b0;
        n        = 0;
        ov_seen  = 1'b0;
        while (error !== 1'b1 && n < RST_CYC + TIMEOUT + 20) begin
            tick();
            n++;
            if (out_valid === 1'b1) ov_seen = 1'b1;
        end
        checkOutput("timeout_window", (n >= RST_CYC + TIMEOUT) && (n <= RST_CYC + TIMEOUT + 1), 1);
        checkOutput("timeout_core_reset", core_reset, 1);
        checkOutput("timeout_in_ready", in_ready, 1);
        checkOutput("timeout_core_in", core_in, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid === 1'b1) ov_seen = 1'b1;
        end
        checkOutput("timeout_no_out_valid", ov_seen, 0);
        checkOutput("timeout_error_sticky", error, 1);
        tie_high = 1'b0;
        doReset();
        checkOutput("error_cleared_by_reset", error, 0);

        dsame = randWord();
        applyStimulus(dsame, randMask(), 1, 0, modelPermute(dsame), s0a, ra);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
